matrix_calc_engine: RTL

- Compute responder for the top-level controller FSM. The controller holds `start_calc` high while in its COMPUTE state and drives `op_type`. This block returns `calc_done` and `error_out`; `error_out` feeds the controller's `error_in`.
- Latches operand matrices A and B, a scalar and the dimensions from the matrix storage block.
- Streams the result matrix in row-major order to the display/UART path.

---
 rtl/matrix_calc_engine.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_calc_engine.sv
// matrix_calc_engine
//   Compute responder for the top-level controller. A rising edge on start_calc
//   (sampled in IDLE) latches the operands, the dimensions and op_type, checks
//   the request, and then either pulses error_out or streams the result matrix
//   in row-major order and pulses calc_done.
//
//   Optional build macro: MATCALC_SAT_EN clamps every res_data value to the
//   signed ELEM_W range (sign-extended to ACC_W). The accumulator stays full width.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start_calc              level from controller, rising edge starts an operation
//   op_type                 0001 transpose, 0010 add, 0100 scalar mul, 1000 matmul
//   a_flat, b_flat          operand matrices, element (r,c) at (r*MAX_DIM+c)*ELEM_W
//   a_rows..b_cols          operand dimensions
//   scalar                  signed scalar for scalar multiply
//   busy                    high from CHECK through DONE
//   res_valid/data/row/col  one strobe per result element
//   res_rows, res_cols      result dimensions, valid from RUN until the next start
//   calc_done, error_out    one-cycle completion / illegal-request pulses
//
// State table
//   IDLE  | waiting for a start edge
//   CHECK | validating op_type and dimensions
//   RUN   | computing one element (or one MAC) per cycle
//   DONE  | last element issued, calc_done follows
//   ERR   | error_out is high for this cycle
module matrix_calc_engine #(
  parameter int MAX_DIM = 5,
  parameter int DIM_W   = 3,
  parameter int ELEM_W  = 8,
  parameter int ACC_W   = 20
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_calc,
  input  logic [3:0]                        op_type,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] a_flat,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0] b_flat,
  input  logic [DIM_W-1:0]                  a_rows,
  input  logic [DIM_W-1:0]                  a_cols,
  input  logic [DIM_W-1:0]                  b_rows,
  input  logic [DIM_W-1:0]                  b_cols,
  input  logic [ELEM_W-1:0]                 scalar,
  output logic                              busy,
  output logic                              res_valid,
  output logic [ACC_W-1:0]                  res_data,
  output logic [DIM_W-1:0]                  res_row,
  output logic [DIM_W-1:0]                  res_col,
  output logic [DIM_W-1:0]                  res_rows,
  output logic [DIM_W-1:0]                  res_cols,
  output logic                              calc_done,
  output logic                              error_out
);

  localparam logic [3:0] OP_TRANS = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SCAL  = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_DONE, S_ERR} state_t;

  state_t                     state;
  logic                       start_q;
  logic [3:0]                 op_q;
  logic signed [ELEM_W-1:0]   a_mem [MAX_DIM][MAX_DIM];
  logic signed [ELEM_W-1:0]   b_mem [MAX_DIM][MAX_DIM];
  logic [DIM_W-1:0]           a_rows_q, a_cols_q, b_rows_q, b_cols_q;
  logic signed [ELEM_W-1:0]   scalar_q;
  logic [DIM_W-1:0]           r_cnt, c_cnt, k_cnt;
  logic signed [ACC_W-1:0]    acc;

  logic                       chk_err;
  logic                       a_bad, b_bad;
  logic [DIM_W-1:0]           rows_n, cols_n;
  logic signed [ACC_W-1:0]    ew_val, mac_prod, mac_sum;
  logic                       last_col, last_row, last_k;

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || (d > DIM_MAX);
  endfunction

  function automatic logic signed [ACC_W-1:0] out_fmt(input logic signed [ACC_W-1:0] v);
`ifdef MATCALC_SAT_EN
    logic signed [ACC_W-1:0] sat_hi;
    logic signed [ACC_W-1:0] sat_lo;
    sat_hi = ACC_W'((2 ** (ELEM_W - 1)) - 1);
    sat_lo = ACC_W'(-(2 ** (ELEM_W - 1)));
    if (v > sat_hi) return sat_hi;
    else if (v < sat_lo) return sat_lo;
    else return v;
`else
    return v;
`endif
  endfunction

  // Request validation and result shape, evaluated on the latched request.
  always_comb begin
    a_bad   = dim_bad(a_rows_q) || dim_bad(a_cols_q);
    b_bad   = dim_bad(b_rows_q) || dim_bad(b_cols_q);
    chk_err = 1'b1;
    rows_n  = a_rows_q;
    cols_n  = a_cols_q;
    case (op_q)
      OP_TRANS: begin
        chk_err = a_bad;
        rows_n  = a_cols_q;
        cols_n  = a_rows_q;
      end
      OP_SCAL:  chk_err = a_bad;
      OP_ADD:   chk_err = a_bad || b_bad || (a_rows_q != b_rows_q) || (a_cols_q != b_cols_q);
      OP_MUL: begin
        chk_err = a_bad || b_bad || (a_cols_q != b_rows_q);
        cols_n  = b_cols_q;
      end
      default:  chk_err = 1'b1;
    endcase
  end

  // Per-cycle arithmetic for the current (r,c[,k]) position.
  always_comb begin
    ew_val = '0;
    case (op_q)
      OP_TRANS: ew_val = ACC_W'(a_mem[c_cnt][r_cnt]);
      OP_ADD:   ew_val = ACC_W'(a_mem[r_cnt][c_cnt]) + ACC_W'(b_mem[r_cnt][c_cnt]);
      OP_SCAL:  ew_val = ACC_W'(scalar_q) * ACC_W'(a_mem[r_cnt][c_cnt]);
      default:  ew_val = '0;
    endcase
    mac_prod = ACC_W'(a_mem[r_cnt][k_cnt]) * ACC_W'(b_mem[k_cnt][c_cnt]);
    // First k of each element restarts the sum instead of adding to the old one.
    mac_sum  = ((k_cnt == '0) ? '0 : acc) + mac_prod;
    last_col = (c_cnt == res_cols - 1'b1);
    last_row = (r_cnt == res_rows - 1'b1);
    last_k   = (k_cnt == a_cols_q - 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      op_q      <= '0;
      a_rows_q  <= '0;
      a_cols_q  <= '0;
      b_rows_q  <= '0;
      b_cols_q  <= '0;
      scalar_q  <= '0;
      r_cnt     <= '0;
      c_cnt     <= '0;
      k_cnt     <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_col   <= '0;
      res_rows  <= '0;
      res_cols  <= '0;
      calc_done <= 1'b0;
      error_out <= 1'b0;
      for (int i = 0; i < MAX_DIM; i++) begin
        for (int j = 0; j < MAX_DIM; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
        end
      end
    end else begin
      start_q <= start_calc;
      case (state)
        S_IDLE: begin
          res_valid <= 1'b0;
          calc_done <= 1'b0;
          error_out <= 1'b0;
          if (start_calc && !start_q) begin
            state    <= S_CHECK;
            busy     <= 1'b1;
            op_q     <= op_type;
            a_rows_q <= a_rows;
            a_cols_q <= a_cols;
            b_rows_q <= b_rows;
            b_cols_q <= b_cols;
            scalar_q <= scalar;
            r_cnt    <= '0;
            c_cnt    <= '0;
            k_cnt    <= '0;
            res_rows <= '0;
            res_cols <= '0;
            for (int i = 0; i < MAX_DIM; i++) begin
              for (int j = 0; j < MAX_DIM; j++) begin
                a_mem[i][j] <= a_flat[(i*MAX_DIM+j)*ELEM_W +: ELEM_W];
                b_mem[i][j] <= b_flat[(i*MAX_DIM+j)*ELEM_W +: ELEM_W];
              end
            end
          end
        end
        S_CHECK: begin
          if (!start_calc) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (chk_err) begin
            state     <= S_ERR;
            error_out <= 1'b1;
          end else begin
            state    <= S_RUN;
            res_rows <= rows_n;
            res_cols <= cols_n;
          end
        end
        S_RUN: begin
          if (!start_calc) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
          end else begin
            res_valid <= 1'b0;
            if (op_q == OP_MUL) begin
              acc <= mac_sum;
              if (last_k) begin
                k_cnt     <= '0;
                res_valid <= 1'b1;
                res_data  <= out_fmt(mac_sum);
              end else begin
                k_cnt <= k_cnt + 1'b1;
              end
            end else begin
              res_valid <= 1'b1;
              res_data  <= out_fmt(ew_val);
            end
            if ((op_q != OP_MUL) || last_k) begin
              res_row <= r_cnt;
              res_col <= c_cnt;
              if (last_col) begin
                c_cnt <= '0;
                if (last_row) state <= S_DONE;
                else          r_cnt <= r_cnt + 1'b1;
              end else begin
                c_cnt <= c_cnt + 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          res_valid <= 1'b0;
          calc_done <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_ERR: begin
          error_out <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
